// File: rtl/result_scroller_pkg.sv
// Shared types and seven-segment constants for the result scroller.
// Segment bytes are active-low, bit 7 = dp, bit 6 = g ... bit 0 = a.
package result_scroller_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCROLL,
    S_WINNER
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  localparam logic [9:0][7:0] SEG_TABLE = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] bcd_seg(input logic [3:0] d);
    bcd_seg = (d < 4'd10) ? SEG_TABLE[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/result_scroller_tick.sv
// Free-running tick divider: one-cycle tick_o every CLK_PER_TICK cycles,
// restarted from zero by a synchronous clear.
module tick_gen #(
  parameter int unsigned CLK_PER_TICK = 10_000_000
) (
  input  logic clk_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_TICK - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (clr_i || cnt_q == LAST) cnt_q <= '0;
    else                        cnt_q <= cnt_q + 1'b1;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/result_scroller.sv
// Scrolls each player's score across an 8-digit display, then shows the winner.
// Define RESULT_SCROLLER_LOOP_EN to cycle back from WINNER to the scroll.
module result_scroller
  import result_scroller_pkg::*;
#(
  parameter int unsigned MAX_PLAYERS    = 4,
  parameter int unsigned SCORE_W        = 7,
  parameter int unsigned CLK_PER_TICK   = 10_000_000,
  parameter int unsigned TICKS_PER_STEP = 10,
  parameter int unsigned VIEW_ID        = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [2:0]                     view,
  input  logic [3:0]                     player_count,
  input  logic [MAX_PLAYERS*SCORE_W-1:0] scores,
  input  logic [3:0]                     winner,
  input  logic                           skip,
  output logic [63:0]                    seg_digits,
  output logic [3:0]                     cur_player,
  output logic                           done
);

  localparam int unsigned TC_W = $clog2(4 * TICKS_PER_STEP + 1);
  localparam logic [TC_W-1:0] STEP_LAST = TC_W'(TICKS_PER_STEP - 1);
`ifdef RESULT_SCROLLER_LOOP_EN
  localparam logic [TC_W-1:0] WIN_LAST = TC_W'(4 * TICKS_PER_STEP - 1);
`endif

  state_e             state_q, state_d;
  logic [3:0]         player_q, player_d, next_player;
  logic [1:0]         pos_q, pos_d;
  logic [TC_W-1:0]    tcnt_q, tcnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               bad_q, bad_d;
  logic               done_q, done_d;
  logic [63:0]        seg_q, seg_d;
  logic               active, tick, tick_clr, load_scroll, load_win;
  logic [3:0]         eff;

  function automatic logic [SCORE_W-1:0] score_of(input logic [3:0] p,
                                                  input logic [MAX_PLAYERS*SCORE_W-1:0] v);
    score_of = '0;
    for (int unsigned i = 0; i < MAX_PLAYERS; i++)
      if (32'(p) == i + 1) score_of = v[i*SCORE_W +: SCORE_W];
  endfunction

  assign active = !rst && (32'(view) == VIEW_ID);
  assign eff    = (32'(player_count) > MAX_PLAYERS) ? 4'(MAX_PLAYERS) : player_count;

  tick_gen #(.CLK_PER_TICK(CLK_PER_TICK)) u_tick (
    .clk_i (clk),
    .clr_i (tick_clr),
    .tick_o(tick)
  );

  // Frame entry is funnelled through load_scroll/load_win so every entry
  // samples its score and restarts the tick divider the same way.
  always_comb begin
    state_d     = state_q;
    player_d    = player_q;
    pos_d       = pos_q;
    tcnt_d      = tcnt_q;
    score_d     = score_q;
    bad_d       = bad_q;
    done_d      = 1'b0;
    tick_clr    = 1'b0;
    load_scroll = 1'b0;
    load_win    = 1'b0;
    next_player = player_q + 4'd1;
    if (!active) begin
      state_d  = S_IDLE;
      player_d = '0;
      pos_d    = '0;
      tcnt_d   = '0;
      score_d  = '0;
      bad_d    = 1'b0;
      tick_clr = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          next_player = 4'd1;
          if (eff == '0) load_win = 1'b1;
          else           load_scroll = 1'b1;
        end
        S_SCROLL: begin
          if (skip || (tick && tcnt_q == STEP_LAST && pos_q == 2'd3)) begin
            if (player_q >= eff) load_win = 1'b1;
            else                 load_scroll = 1'b1;
          end else if (tick) begin
            if (tcnt_q == STEP_LAST) begin
              tcnt_d = '0;
              pos_d  = pos_q + 2'd1;
            end else begin
              tcnt_d = tcnt_q + 1'b1;
            end
          end
        end
        S_WINNER: begin
`ifdef RESULT_SCROLLER_LOOP_EN
          next_player = 4'd1;
          if (skip || (tick && tcnt_q == WIN_LAST)) begin
            if (eff == '0) load_win = 1'b1;
            else           load_scroll = 1'b1;
          end else if (tick) begin
            tcnt_d = tcnt_q + 1'b1;
          end
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (load_scroll) begin
      state_d  = S_SCROLL;
      player_d = next_player;
      pos_d    = '0;
      tcnt_d   = '0;
      score_d  = score_of(next_player, scores);
      bad_d    = 1'b0;
      tick_clr = 1'b1;
    end
    if (load_win) begin
      state_d  = S_WINNER;
      player_d = winner;
      pos_d    = '0;
      tcnt_d   = '0;
      score_d  = score_of(winner, scores);
      bad_d    = (winner == '0) || (winner > eff);
      done_d   = 1'b1;
      tick_clr = 1'b1;
    end
  end

  logic [9:0]      sc;
  logic [3:0]      hund, tens, ones;
  logic [4:0][7:0] fr;
  logic [7:0][7:0] disp;

  // disp[7] is digit 0 (leftmost), so digit d lives at disp[7-d].
  always_comb begin
    sc    = 10'(score_q);
    hund  = 4'(sc / 10'd100);
    tens  = 4'((sc / 10'd10) % 10'd10);
    ones  = 4'(sc % 10'd10);
    fr[0] = bcd_seg(player_q);
    fr[1] = SEG_BLANK;
    fr[2] = (hund == '0) ? SEG_BLANK : bcd_seg(hund);
    fr[3] = (hund == '0 && tens == '0) ? SEG_BLANK : bcd_seg(tens);
    fr[4] = bcd_seg(ones);
    disp  = '1;
    case (state_q)
      S_SCROLL: begin
        for (int unsigned d = 0; d < 8; d++)
          if (d >= 32'(pos_q) && d < 32'(pos_q) + 5)
            disp[3'(7 - d)] = fr[3'(d - 32'(pos_q))];
      end
      S_WINNER: begin
        disp[3] = bad_q ? SEG_DASH : bcd_seg(player_q);
        disp[1] = bad_q ? SEG_DASH : bcd_seg(tens);
        disp[0] = bad_q ? SEG_DASH : bcd_seg(ones);
      end
      default: disp = '1;
    endcase
    seg_d = active ? disp : '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      player_q <= '0;
      pos_q    <= '0;
      tcnt_q   <= '0;
      score_q  <= '0;
      bad_q    <= 1'b0;
      done_q   <= 1'b0;
      seg_q    <= '1;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      pos_q    <= pos_d;
      tcnt_q   <= tcnt_d;
      score_q  <= score_d;
      bad_q    <= bad_d;
      done_q   <= done_d;
      seg_q    <= seg_d;
    end
  end

  assign seg_digits = seg_q;
  assign cur_player = player_q;
  assign done       = done_q;

endmodule

// File: tb/tb_result_scroller.sv
// Directed bench for result_scroller: per-cycle expectations are queued when
// stimulus is applied and checked on following falling edges.
module tb_result_scroller;

  localparam int unsigned MAXP = 4;
  localparam int unsigned SW   = 7;

  logic              clk = 1'b0;
  logic              rst, skip;
  logic [2:0]        view;
  logic [3:0]        player_count, winner;
  logic [MAXP*SW-1:0] scores;
  logic [63:0]       seg_digits;
  logic [3:0]        cur_player;
  logic              done;

  typedef struct packed {
    logic [63:0] seg;
    logic [3:0]  cur;
    logic        done;
    logic        chk_seg;
  } exp_t;

  exp_t  q[$];
  string tq[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  result_scroller #(
    .MAX_PLAYERS   (MAXP),
    .SCORE_W       (SW),
    .CLK_PER_TICK  (4),
    .TICKS_PER_STEP(2),
    .VIEW_ID       (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .view        (view),
    .player_count(player_count),
    .scores      (scores),
    .winner      (winner),
    .skip        (skip),
    .seg_digits  (seg_digits),
    .cur_player  (cur_player),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sg(input int d);
    case (d)
      0: sg = 8'hC0;  1: sg = 8'hF9;  2: sg = 8'hA4;  3: sg = 8'hB0;  4: sg = 8'h99;
      5: sg = 8'h92;  6: sg = 8'h82;  7: sg = 8'hF8;  8: sg = 8'h80;  9: sg = 8'h90;
      default: sg = 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] scroll_img(input int p, input int s, input int pos);
    logic [7:0]  f[5];
    logic [63:0] r;
    f[0] = sg(p);
    f[1] = 8'hFF;
    f[2] = (s >= 100) ? sg(s / 100) : 8'hFF;
    f[3] = (s >= 10) ? sg((s / 10) % 10) : 8'hFF;
    f[4] = sg(s % 10);
    r = '1;
    for (int i = 0; i < 5; i++) r[63 - 8*(pos + i) -: 8] = f[i];
    return r;
  endfunction

  function automatic logic [63:0] win_img(input int w, input int s, input bit bad);
    logic [63:0] r;
    r = '1;
    r[31:24] = bad ? 8'hBF : sg(w);
    r[15:8]  = bad ? 8'hBF : sg((s % 100) / 10);
    r[7:0]   = bad ? 8'hBF : sg(s % 10);
    return r;
  endfunction

  task automatic push(input string t, input logic [63:0] s, input logic [3:0] c,
                      input logic d, input logic cs);
    exp_t e;
    e.seg = s; e.cur = c; e.done = d; e.chk_seg = cs;
    q.push_back(e);
    tq.push_back(t);
  endtask

  task automatic adv(input int n);
    exp_t  e;
    string t;
    repeat (n) begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        t = tq.pop_front();
        n_assert++;
        assert (cur_player === e.cur) else begin
          n_fail++;
          $error("FAIL %s cur_player observed=%0d expected=%0d", t, cur_player, e.cur);
        end
        n_assert++;
        assert (done === e.done) else begin
          n_fail++;
          $error("FAIL %s done observed=%0b expected=%0b", t, done, e.done);
        end
        if (e.chk_seg) begin
          n_assert++;
          assert (seg_digits === e.seg) else begin
            n_fail++;
            $error("FAIL %s seg_digits observed=%h expected=%h", t, seg_digits, e.seg);
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_hold, done_seen;
    rst = 1'b1; skip = 1'b0; view = 3'd2; player_count = 4'd2; winner = 4'd2;
    scores = {7'd0, 7'd40, 7'd123, 7'd5};

    // Reset, then a full p1/p2 scroll into WINNER.
    push("reset", '1, 4'd0, 1'b0, 1'b1);
    push("reset", '1, 4'd0, 1'b0, 1'b1);
    adv(2);
    rst = 1'b0;
    push("rst_release", '1, 4'd1, 1'b0, 1'b1);
    for (int k = 1; k <= 31; k++) push("p1_scroll", scroll_img(1, 5, (k - 1) / 8), 4'd1, 1'b0, 1'b1);
    push("p1_last", scroll_img(1, 5, 3), 4'd2, 1'b0, 1'b1);
    for (int k = 33; k <= 63; k++) push("p2_scroll", scroll_img(2, 123, (k - 33) / 8), 4'd2, 1'b0, 1'b1);
    push("win_entry", scroll_img(2, 123, 3), 4'd2, 1'b1, 1'b1);
    push("win_frame", win_img(2, 123, 0), 4'd2, 1'b0, 1'b1);
    adv(66);

`ifdef RESULT_SCROLLER_LOOP_EN
    for (int k = 66; k <= 95; k++) push("win_hold", win_img(2, 123, 0), 4'd2, 1'b0, 1'b1);
    push("loop_p1", win_img(2, 123, 0), 4'd1, 1'b0, 1'b1);
    push("loop_p1_frame", scroll_img(1, 5, 0), 4'd1, 1'b0, 1'b1);
    for (int k = 98; k <= 159; k++) push("loop_scroll", '0, (k < 128) ? 4'd1 : 4'd2, 1'b0, 1'b0);
    push("loop_done", '0, 4'd2, 1'b1, 1'b0);
    adv(95);
`else
    bad_hold = 0; done_seen = 0;
    repeat (4000) begin
      @(negedge clk);
      if (done !== 1'b0) done_seen++;
      if (seg_digits !== win_img(2, 123, 0) || cur_player !== 4'd2) bad_hold++;
    end
    n_assert++;
    assert (done_seen === 0) else begin
      n_fail++;
      $error("FAIL win_hold_done observed=%0d expected=0", done_seen);
    end
    n_assert++;
    assert (bad_hold === 0) else begin
      n_fail++;
      $error("FAIL win_hold_frame observed=%0d expected=0", bad_hold);
    end
`endif

    // Leave the view, come back, skip mid-frame, abort mid-scroll.
    view = 3'd0;
    push("view_off", '1, 4'd0, 1'b0, 1'b1);
    push("view_off", '1, 4'd0, 1'b0, 1'b1);
    adv(2);
    view = 3'd2;
    push("view_back", '1, 4'd1, 1'b0, 1'b1);
    for (int j = 1; j <= 10; j++) push("resume_p1", scroll_img(1, 5, (j - 1) / 8), 4'd1, 1'b0, 1'b1);
    adv(11);
    skip = 1'b1;
    push("skip_mid", scroll_img(1, 5, 1), 4'd2, 1'b0, 1'b1);
    adv(1);
    skip = 1'b0;
    push("skip_p2_pos0", scroll_img(2, 123, 0), 4'd2, 1'b0, 1'b1);
    adv(1);
    view = 3'd5;
    for (int j = 0; j < 3; j++) push("abort", '1, 4'd0, 1'b0, 1'b1);
    adv(3);
    view = 3'd2;
    push("restart", '1, 4'd1, 1'b0, 1'b1);
    for (int m = 1; m <= 7; m++) push("restart_p1", scroll_img(1, 5, 0), 4'd1, 1'b0, 1'b1);
    adv(8);
    skip = 1'b1;
    push("skip_step", scroll_img(1, 5, 0), 4'd2, 1'b0, 1'b1);
    adv(1);
    skip = 1'b0;
    push("skip_step_p2", scroll_img(2, 123, 0), 4'd2, 1'b0, 1'b1);
    push("skip_step_p2", scroll_img(2, 123, 0), 4'd2, 1'b0, 1'b1);
    adv(2);
    skip = 1'b1;
    push("skip_last", scroll_img(2, 123, 0), 4'd2, 1'b1, 1'b1);
    adv(1);
    skip = 1'b0;
    push("skip_win", win_img(2, 123, 0), 4'd2, 1'b0, 1'b1);
    adv(1);

    // Count clamped to MAX_PLAYERS, zero score, out-of-range winner.
    rst = 1'b1; player_count = 4'd7; winner = 4'd5;
    push("reset2", '1, 4'd0, 1'b0, 1'b1);
    push("reset2", '1, 4'd0, 1'b0, 1'b1);
    adv(2);
    rst = 1'b0;
    push("cnt7_start", '1, 4'd1, 1'b0, 1'b1);
    adv(1);
    skip = 1'b1;
    push("cnt7_p2", scroll_img(1, 5, 0), 4'd2, 1'b0, 1'b1);
    push("cnt7_p3", scroll_img(2, 123, 0), 4'd3, 1'b0, 1'b1);
    push("cnt7_p4", scroll_img(3, 40, 0), 4'd4, 1'b0, 1'b1);
    adv(3);
    skip = 1'b0;
    push("cnt7_p4_frame", scroll_img(4, 0, 0), 4'd4, 1'b0, 1'b1);
    adv(1);
    skip = 1'b1;
    push("cnt7_win", scroll_img(4, 0, 0), 4'd5, 1'b1, 1'b1);
    adv(1);
    skip = 1'b0;
    push("dash_frame", win_img(5, 0, 1), 4'd5, 1'b0, 1'b1);
    adv(1);

    // Zero players: straight to WINNER on the first active cycle.
    rst = 1'b1; player_count = 4'd0; winner = 4'd1;
    push("reset3", '1, 4'd0, 1'b0, 1'b1);
    push("reset3", '1, 4'd0, 1'b0, 1'b1);
    adv(2);
    rst = 1'b0;
    push("cnt0_win", '1, 4'd1, 1'b1, 1'b1);
    push("cnt0_dash", win_img(1, 0, 1), 4'd1, 1'b0, 1'b1);
    adv(2);
`ifndef RESULT_SCROLLER_LOOP_EN
    skip = 1'b1;
    push("skip_ignored", win_img(1, 0, 1), 4'd1, 1'b0, 1'b1);
    adv(1);
    skip = 1'b0;
    push("skip_ignored", win_img(1, 0, 1), 4'd1, 1'b0, 1'b1);
    adv(1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/result_scroller.md
RESULT_SCROLLER -- requirements
Module: result_scroller

Interface
REQ-001 Parameter MAX_PLAYERS, default 4, upper bound on players displayed (1..9).
REQ-002 Parameter SCORE_W, default 7, score width in bits (1..9, so every score fits 3 decimal digits).
REQ-003 Parameter CLK_PER_TICK, default 10_000_000, clk cycles per display tick (100 ms at 100 MHz).
REQ-004 Parameter TICKS_PER_STEP, default 10, ticks per scroll step.
REQ-005 Parameter VIEW_ID, default 2, view code that activates the block.
REQ-006 clk  in  1  system clock; the block has one clock and a synchronous, active-high reset.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 view  in  3  current view code; the block is active only when view==VIEW_ID.
REQ-009 player_count  in  4  number of players to show.
REQ-010 scores  in  MAX_PLAYERS*SCORE_W  packed scores, player 1 in the LSBs.
REQ-011 winner  in  4  winning player number, 1-based.
REQ-012 skip  in  1  one-cycle pulse that advances to the next frame immediately.
REQ-013 seg_digits  out  64  eight active-low segment bytes, digit 0 leftmost in bits [63:56], ready for seg_tube.
REQ-014 cur_player  out  4  player currently shown; 0 in IDLE; winner number in WINNER.
REQ-015 done  out  1  one-cycle pulse on entry to WINNER.

Function
REQ-016 The FSM SHALL have the states IDLE, SCROLL and WINNER.
REQ-017 While inactive (rst, or view!=VIEW_ID), state, counters and outputs SHALL be held at reset values.
REQ-018 In IDLE, on the first active cycle, the block SHALL go to SCROLL with player=1 and pos=0; if the effective count is 0 it SHALL go straight to WINNER.
REQ-019 The effective count SHALL be min(player_count, MAX_PLAYERS).
REQ-020 The SCROLL frame SHALL be five digits: player digit, blank, then a 3-digit score with leading zeros blanked (score 0 shows a single "0").
REQ-021 The frame SHALL start at digit pos; digits outside the frame SHALL be blank (8'hFF).
REQ-022 pos SHALL run 0..3 and advance by 1 every TICKS_PER_STEP ticks.
REQ-023 After pos=3 has been held for a full step, the block SHALL go to the next player with pos=0 and the tick count cleared.
REQ-024 After the last player, the block SHALL go to WINNER.
REQ-025 On a skip pulse in SCROLL, the block SHALL advance exactly as in REQ-023/024 on the next cycle; skip SHALL take priority over a coincident step.
REQ-026 skip in IDLE or WINNER SHALL be ignored unless the loop macro (REQ-035) is defined.
REQ-027 The WINNER frame SHALL be: digits 0-3 blank, digit 4 the winner number, digit 5 blank, digits 6-7 the winner score mod 100, with the tens digit always shown.
REQ-028 If winner is 0 or greater than the effective count, digits 4, 6 and 7 SHALL show "-" (8'hBF).
REQ-029 The player selection and score SHALL be sampled when the frame is entered, and SHALL be stable for the whole frame.
REQ-030 Score decode SHALL be combinational from the registered score; seg_digits SHALL be registered, giving 1 cycle latency from a state change to the output.

Reset
REQ-031 On rst: state=IDLE, pos=0, player=0, tick and step counters=0, seg_digits=all 8'hFF, cur_player=0, done=0.
REQ-032 rst or a view change in mid-scroll SHALL abort within 1 cycle, with no done pulse.

Configuration
REQ-033 Macro RESULT_SCROLLER_LOOP_EN selects the WINNER behaviour.
REQ-034 Without RESULT_SCROLLER_LOOP_EN, WINNER SHALL be terminal until the block becomes inactive.
REQ-035 With RESULT_SCROLLER_LOOP_EN, the block SHALL leave WINNER after 4*TICKS_PER_STEP ticks, or on skip, and restart SCROLL at player 1, with done pulsing on each WINNER entry.

Structure
REQ-036 A shared package SHALL hold the state enum, SEG_BLANK=8'hFF, SEG_DASH=8'hBF and the digit-to-segment table shared with bcd_seg.
REQ-037 One sub-module, tick_gen (parameter CLK_PER_TICK, synchronous clear), SHALL produce a single-cycle tick pulse and be cleared while inactive.

Verification
REQ-038 CLK_PER_TICK=4, TICKS_PER_STEP=2, count=2, scores {p1=5,p2=123}: the p1 frame lasts 4 steps of 8 cycles = 32 cycles; pos0 digits = "1",blank,blank,blank,"5",blank,blank,blank.
REQ-039 Same setup, player 2 at pos=3: digits 3-7 = "2",blank,"1","2","3"; WINNER with winner=2 shows digit4="2", digits6-7="23", and done pulses once.
REQ-040 A skip pulse mid-frame for p1 makes cur_player=2 the next cycle with pos=0; skip coincident with a step advances exactly one player.
REQ-041 player_count=7 with MAX_PLAYERS=4 scrolls exactly 4 players; player_count=0 goes to WINNER on the first active cycle; winner=5 shows dashes.
REQ-042 view changed away mid-scroll -> seg_digits all 8'hFF next cycle, no done pulse; returning to view restarts at player 1, pos 0.
REQ-043 With RESULT_SCROLLER_LOOP_EN: after 8 ticks in WINNER, player 1 is shown again and done pulses again on the next WINNER entry; without the macro, WINNER holds for 1000 ticks.
